// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit accumulator CPU: opcodes, sequencer states
// and the opcode classification used by the sequencing controller.
package cpu_pkg;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [3:0] {
        INST_ADDR  = 4'd0,
        INST_FETCH = 4'd1,
        INST_LOAD  = 4'd2,
        IDLE       = 4'd3,
        OP_ADDR    = 4'd4,
        OP_FETCH   = 4'd5,
        ALU_OP     = 4'd6,
        STORE      = 4'd7,
        HALT       = 4'd8
    } state_t;

    localparam int unsigned PHASE_W    = 3;
    localparam logic [2:0]  HALT_PHASE = 3'b111;

    // Opcodes that read an operand from memory into the accumulator.
    function automatic logic is_aluop(input opcode_t op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/seq_ctrl.sv
// Instruction-sequencing controller: 8-phase fetch/execute state machine with
// combinational decode of (state, opcode, zero) into datapath strobes.
module seq_ctrl
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_,
    input  opcode_t            opcode,
    input  logic               zero,
    output logic               sel,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               load_ir,
    output logic               load_ac,
    output logic               load_pc,
    output logic               inc_pc,
    output logic               data_e,
    output logic               halt,
    output logic [PHASE_W-1:0] phase
);

    state_t r_state;
    state_t w_next;
    logic   w_aluop;

    assign w_aluop = is_aluop(opcode);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= INST_ADDR;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and strobe decode.
    always_comb begin
        w_next  = INST_ADDR;
        sel     = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        load_ir = 1'b0;
        load_ac = 1'b0;
        load_pc = 1'b0;
        inc_pc  = 1'b0;
        data_e  = 1'b0;
        halt    = 1'b0;
        phase   = r_state[PHASE_W-1:0];

        unique case (r_state)
            INST_ADDR: begin
                sel    = 1'b1;
                w_next = INST_FETCH;
            end
            INST_FETCH: begin
                sel    = 1'b1;
                mem_rd = 1'b1;
                w_next = INST_LOAD;
            end
            INST_LOAD: begin
                sel     = 1'b1;
                mem_rd  = 1'b1;
                load_ir = 1'b1;
                w_next  = IDLE;
            end
            IDLE: begin
                sel     = 1'b1;
                mem_rd  = 1'b1;
                load_ir = 1'b1;
                w_next  = OP_ADDR;
            end
            OP_ADDR: begin
                inc_pc = (opcode != HLT);
                halt   = (opcode == HLT);
                w_next = (opcode == HLT) ? HALT : OP_FETCH;
            end
            OP_FETCH: begin
                mem_rd = w_aluop;
                w_next = ALU_OP;
            end
            ALU_OP: begin
                mem_rd  = w_aluop;
                load_ac = w_aluop;
                inc_pc  = (opcode == SKZ) && zero;
                load_pc = (opcode == JMP);
                data_e  = (opcode == STO);
                w_next  = STORE;
            end
            STORE: begin
                mem_rd  = w_aluop;
                load_ac = w_aluop;
                load_pc = (opcode == JMP);
                inc_pc  = (opcode == JMP);
                mem_wr  = (opcode == STO);
                data_e  = (opcode == STO);
                w_next  = INST_ADDR;
            end
            HALT: begin
                halt   = 1'b1;
                phase  = HALT_PHASE;
                w_next = HALT;
            end
            default: begin
                sel    = 1'b1;
                phase  = '0;
                w_next = INST_ADDR;
            end
        endcase
    end

    a_rd_wr_excl: assert property (@(posedge clk) disable iff (!rst_) !(mem_rd && mem_wr));

endmodule

// File: tb/tb_seq_ctrl.sv
// Scoreboard bench for seq_ctrl: the driver queues expected strobe vectors per
// cycle from a phase-table model; a negedge monitor pops and compares.
module tb_seq_ctrl;
    import cpu_pkg::*;

    logic       clk;
    logic       rst_;
    opcode_t    opcode;
    logic       zero;
    logic       sel, mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, data_e, halt;
    logic [2:0] phase;

    logic [11:0] act;
    logic [11:0] exp_q[$];
    int          n_checks;
    int          n_fail;

    seq_ctrl dut (
        .clk    (clk),
        .rst_   (rst_),
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .mem_rd (mem_rd),
        .mem_wr (mem_wr),
        .load_ir(load_ir),
        .load_ac(load_ac),
        .load_pc(load_pc),
        .inc_pc (inc_pc),
        .data_e (data_e),
        .halt   (halt),
        .phase  (phase)
    );

    assign act = {sel, mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, data_e, halt, phase};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected outputs for phase p (0..7) of an instruction, or p==8 for HALT.
    function automatic logic [11:0] exp_vec(input int p, input opcode_t op, input logic z);
        logic alu;
        logic e_sel, e_rd, e_wr, e_ir, e_ac, e_pc, e_inc, e_de, e_h;
        logic [2:0] e_ph;
        alu = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
        if (p == 8) return {9'b000000001, 3'b111};
        e_sel = (p <= 3);
        e_rd  = (p >= 1 && p <= 3) || (alu && p >= 5);
        e_wr  = (op == STO) && (p == 7);
        e_ir  = (p == 2) || (p == 3);
        e_ac  = alu && (p >= 6);
        e_pc  = (op == JMP) && (p >= 6);
        e_inc = (p == 4 && op != HLT) || (p == 6 && op == SKZ && z) || (p == 7 && op == JMP);
        e_de  = (op == STO) && (p >= 6);
        e_h   = (p == 4) && (op == HLT);
        e_ph  = 3'(p);
        return {e_sel, e_rd, e_wr, e_ir, e_ac, e_pc, e_inc, e_de, e_h, e_ph};
    endfunction

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b want %b (sel,rd,wr,ir,ac,pc,inc,de,halt,phase) op=%0d zero=%0b",
                     name, got, want, opcode, zero);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) check("scoreboard", act, exp_q.pop_front());
    end

    // Hold reset for one sampled cycle, release just after the next edge.
    task automatic do_reset();
        rst_ = 1'b0;
        exp_q.push_back(exp_vec(0, HLT, 1'b0));
        @(posedge clk); #1;
        rst_ = 1'b1;
    endtask

    task automatic run_instr(input opcode_t op, input logic z, input bit rst_at_store);
        bit done;
        done   = 1'b0;
        opcode = op;
        zero   = z;
        for (int p = 0; p < 8 && !done; p++) begin
            if (op == HLT && p == 5) begin
                done = 1'b1;
            end else begin
                exp_q.push_back(exp_vec(p, op, z));
                if (p == 7 && rst_at_store) begin
                    @(negedge clk); #1;
                    rst_ = 1'b0;
                    #1;
                    check("async_reset", act, exp_vec(0, HLT, 1'b0));
                    @(posedge clk); #1;
                    do_reset();
                    done = 1'b1;
                end else begin
                    @(posedge clk); #1;
                end
            end
        end
        if (op == HLT) begin
            for (int i = 0; i < 22; i++) begin
                exp_q.push_back(exp_vec(8, op, z));
                @(posedge clk); #1;
            end
            do_reset();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_     = 1'b0;
        opcode   = ADD;
        zero     = 1'b0;
        @(posedge clk); #1;
        do_reset();

        run_instr(ADD, 1'b0, 1'b0);
        run_instr(STO, 1'b1, 1'b0);
        run_instr(SKZ, 1'b1, 1'b0);
        run_instr(SKZ, 1'b0, 1'b0);
        run_instr(JMP, 1'b0, 1'b0);
        run_instr(LDA, 1'b1, 1'b0);
        run_instr(STO, 1'b0, 1'b1);
        run_instr(HLT, 1'b0, 1'b0);

        for (int k = 0; k < 60; k++) begin
            run_instr(opcode_t'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 9) == 0));
        end
        run_instr(HLT, 1'b1, 1'b0);
        run_instr(XOR, 1'b0, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
